// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU operand selection, MEM/WB forwarding and
// load-use hazard detection for the five-stage RV32I core.
module ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [1:0]  id_src_a_sel,
  input  logic        id_src_b_sel,
  input  logic [3:0]  id_alu_control,
  input  logic        id_reg_write,
  input  logic        id_mem_write,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic [1:0]  id_result_src,
  input  logic        flush_e,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_alu_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic        hazard_stall,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [3:0]  ALUControl,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic [1:0]  ex_result_src,
  output logic [31:0] ex_write_data
);

  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [1:0]  ex_src_a_sel;
  logic        ex_src_b_sel;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic        load_in_ex;
  logic        bubble;

  // A load in EX whose destination is read by decode must wait one cycle;
  // a flush squashes decode anyway, so the stall is suppressed then.
  assign load_in_ex = ex_valid && (ex_result_src == 2'b01) && (ex_rd != 5'd0);

  always_comb begin
    hazard_stall = 1'b0;
    if (load_in_ex && id_valid && !flush_e &&
        ((ex_rd == id_rs1) || (ex_rd == id_rs2)))
      hazard_stall = 1'b1;
  end

  assign bubble = reset || flush_e || hazard_stall;

  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= 32'd0;
      ex_imm        <= 32'd0;
      ex_rd         <= 5'd0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_rs1_data   <= 32'd0;
      ex_rs2_data   <= 32'd0;
      ex_src_a_sel  <= 2'b00;
      ex_src_b_sel  <= 1'b0;
      ALUControl    <= 4'b0000;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_result_src <= 2'b00;
    end else begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_imm        <= id_imm;
      ex_rd         <= id_rd;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rs1_data   <= id_rs1_data;
      ex_rs2_data   <= id_rs2_data;
      ex_src_a_sel  <= id_src_a_sel;
      ex_src_b_sel  <= id_src_b_sel;
      ALUControl    <= id_alu_control;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_branch     <= id_valid && id_branch;
      ex_jump       <= id_valid && id_jump;
      ex_result_src <= id_result_src;
    end
  end

  // MEM is the younger producer, so it takes priority over WB.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (ex_rs1 == 5'd0)
      fwd_rs1 = 32'd0;
    else if (mem_reg_write && (mem_rd == ex_rs1))
      fwd_rs1 = mem_alu_result;
    else if (wb_reg_write && (wb_rd == ex_rs1))
      fwd_rs1 = wb_result;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (ex_rs2 == 5'd0)
      fwd_rs2 = 32'd0;
    else if (mem_reg_write && (mem_rd == ex_rs2))
      fwd_rs2 = mem_alu_result;
    else if (wb_reg_write && (wb_rd == ex_rs2))
      fwd_rs2 = wb_result;
  end

  always_comb begin
    SrcA = 32'd0;
    case (ex_src_a_sel)
      2'b00:   SrcA = fwd_rs1;
      2'b01:   SrcA = ex_pc;
      default: SrcA = 32'd0;
    endcase
    SrcB          = ex_src_b_sel ? ex_imm : fwd_rs2;
    ex_write_data = fwd_rs2;
  end

endmodule
